// File: rtl/dma_word_copier.sv
// Word-by-word block copier that drives the data memory request/stall interface.
// Each word is one read followed by one write, each using a request/stall-high/stall-low handshake.
module dma_word_copier #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [LEN_W-1:0] o_words_done,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_write_data,
    output logic             o_mem_memwrite,
    output logic             o_mem_memread,
    output logic [3:0]       o_mem_sign_mask,
    input  logic [31:0]      i_mem_read_data,
    input  logic             i_mem_clk_stall
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_REQ     = 3'd1,
        S_RD_WAIT_HI = 3'd2,
        S_RD_WAIT_LO = 3'd3,
        S_WR_REQ     = 3'd4,
        S_WR_WAIT_HI = 3'd5,
        S_WR_WAIT_LO = 3'd6,
        S_FINISH     = 3'd7
    } state_t;

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]      WORD_MASK = 4'b0100;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [LEN_W-1:0]   r_len;
    logic [31:0]        r_data;
    logic [LEN_W-1:0]   r_words_done;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [31:0]        r_mem_addr;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_rd;
    logic               r_wr;
    logic [3:0]         r_mask;

    logic               w_start_ok;
    logic               w_misalign;
    logic               w_wait;
    logic               w_timeout;
    logic               w_word_done;
    logic               w_last;
    logic               w_err_set;
    logic               w_busy_d;
    logic               w_done_d;
    logic               w_rd_d;
    logic               w_wr_d;
    logic [31:0]        w_src_next;
    logic [31:0]        w_dst_next;

    assign w_start_ok  = (r_state == S_IDLE) && i_start;
    assign w_misalign  = (i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00);
    assign w_wait      = (r_state == S_RD_WAIT_HI) || (r_state == S_RD_WAIT_LO) ||
                         (r_state == S_WR_WAIT_HI) || (r_state == S_WR_WAIT_LO);
    assign w_timeout   = w_wait && (r_wait_cnt == CNT_LAST);
    assign w_word_done = (r_state == S_WR_WAIT_LO) && !i_mem_clk_stall;
    assign w_last      = (r_words_done + LEN_W'(1)) == r_len;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_misalign) begin
                        w_state_next = S_IDLE;
                        w_err_set    = 1'b1;
                    end else if (i_len == {LEN_W{1'b0}}) begin
                        w_state_next = S_FINISH;
                    end else begin
                        w_state_next = S_RD_REQ;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RD_REQ:     w_state_next = S_RD_WAIT_HI;
            S_RD_WAIT_HI: begin
                if (i_mem_clk_stall) begin
                    w_state_next = S_RD_WAIT_LO;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_state_next = S_RD_WAIT_HI;
                end
            end
            S_RD_WAIT_LO: begin
                if (!i_mem_clk_stall) begin
                    w_state_next = S_WR_REQ;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_state_next = S_RD_WAIT_LO;
                end
            end
            S_WR_REQ:     w_state_next = S_WR_WAIT_HI;
            S_WR_WAIT_HI: begin
                if (i_mem_clk_stall) begin
                    w_state_next = S_WR_WAIT_LO;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_state_next = S_WR_WAIT_HI;
                end
            end
            S_WR_WAIT_LO: begin
                if (!i_mem_clk_stall) begin
                    w_state_next = w_last ? S_FINISH : S_RD_REQ;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_err_set    = 1'b1;
                end else begin
                    w_state_next = S_WR_WAIT_LO;
                end
            end
            S_FINISH:     w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with r_state.
    always_comb begin
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
        w_rd_d   = 1'b0;
        w_wr_d   = 1'b0;
        case (w_state_next)
            S_RD_REQ: begin
                w_busy_d = 1'b1;
                w_rd_d   = 1'b1;
            end
            S_WR_REQ: begin
                w_busy_d = 1'b1;
                w_wr_d   = 1'b1;
            end
            S_RD_WAIT_HI, S_RD_WAIT_LO, S_WR_WAIT_HI, S_WR_WAIT_LO: w_busy_d = 1'b1;
            S_FINISH: w_done_d = 1'b1;
            default:  w_busy_d = 1'b0;
        endcase
    end

    always_comb begin
        w_src_next = r_src;
        w_dst_next = r_dst;
        if (w_start_ok) begin
            w_src_next = i_src_addr;
            w_dst_next = i_dst_addr;
        end else if (w_word_done) begin
            w_src_next = r_src + 32'd4;
            w_dst_next = r_dst + 32'd4;
        end else begin
            w_src_next = r_src;
            w_dst_next = r_dst;
        end
    end

    // Per-state timeout counter restarts whenever the state changes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_state_next != r_state) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_wait) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_src        <= 32'd0;
            r_dst        <= 32'd0;
            r_len        <= {LEN_W{1'b0}};
            r_data       <= 32'd0;
            r_words_done <= {LEN_W{1'b0}};
            r_mem_addr   <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_mask       <= 4'b0000;
        end else begin
            r_busy <= w_busy_d;
            r_done <= w_done_d;
            r_err  <= w_err_set;
            r_rd   <= w_rd_d;
            r_wr   <= w_wr_d;
            r_mask <= (w_rd_d || w_wr_d) ? WORD_MASK : 4'b0000;
            r_src  <= w_src_next;
            r_dst  <= w_dst_next;
            if (w_start_ok) begin
                r_len        <= i_len;
                r_words_done <= {LEN_W{1'b0}};
            end else if (w_word_done) begin
                r_words_done <= r_words_done + LEN_W'(1);
            end
            if ((r_state == S_RD_WAIT_LO) && !i_mem_clk_stall) begin
                r_data <= i_mem_read_data;
            end
            // Address only moves at request cycles and otherwise holds.
            if (w_rd_d) begin
                r_mem_addr <= w_src_next;
            end else if (w_wr_d) begin
                r_mem_addr <= r_dst;
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err            = r_err;
    assign o_words_done     = r_words_done;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_write_data = r_data;
    assign o_mem_memwrite   = r_wr;
    assign o_mem_memread    = r_rd;
    assign o_mem_sign_mask  = r_mask;

endmodule

// File: tb/tb_dma_word_copier.sv
// Scoreboard bench for dma_word_copier: stimulus pushes expected bus events, a monitor pops and compares.
module tb_dma_word_copier;

    localparam int LEN_W = 16;
    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy, done, err;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      maddr, mwdata;
    logic             mwr, mrd;
    logic [3:0]       mask;
    logic [31:0]      rdata = 32'd0;
    logic             stall = 1'b0;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_addr = 32'd0;
    logic [1:0]  mcnt = 2'd0;
    logic        hang;
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_val;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  busy_total = 0;
    int  rd_seen = 0;
    int  wr_seen = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    dma_word_copier #(.LEN_W(LEN_W), .TIMEOUT(64)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
        .o_busy(busy), .o_done(done), .o_err(err), .o_words_done(words_done),
        .o_mem_addr(maddr), .o_mem_write_data(mwdata),
        .o_mem_memwrite(mwr), .o_mem_memread(mrd), .o_mem_sign_mask(mask),
        .i_mem_read_data(rdata), .i_mem_clk_stall(stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: request, two stall cycles, then data valid with stall low.
    always @(posedge clk) begin
        if (rst) begin
            stall <= 1'b0;
            mcnt  <= 2'd0;
        end else if (mrd) begin
            stall   <= 1'b1;
            rd_addr <= maddr;
            mcnt    <= hang ? 2'd0 : 2'd2;
        end else if (mwr) begin
            stall             <= 1'b1;
            mem[maddr[11:2]]  <= mwdata;
            mcnt              <= 2'd2;
        end else if (mcnt == 2'd2) begin
            mcnt <= 2'd1;
        end else if (mcnt == 2'd1) begin
            mcnt  <= 2'd0;
            stall <= 1'b0;
            rdata <= mem[rd_addr[11:2]];
        end
        if (pre_we) mem[pre_idx] <= pre_val;
    end

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic match_event(input int kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        check("event_expected", exp_q.size() != 0, 32'(kind), 32'(exp_q.size()));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("event_kind", kind == e.kind, 32'(kind), 32'(e.kind));
        if (kind == e.kind) begin
            case (kind)
                K_RD: check("rd_addr", addr == e.addr, addr, e.addr);
                K_WR: begin
                    check("wr_addr", addr == e.addr, addr, e.addr);
                    check("wr_data", data == e.data, data, e.data);
                end
                default: begin
                    check("end_words_done", data == e.data, data, e.data);
                    check("end_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                end
            endcase
        end
    endtask

    // Monitor: strobe/mask rules every cycle, then pop the scoreboard on each bus or completion event.
    always @(negedge clk) begin
        if (!rst) begin
            check("sign_mask", mask == ((mrd || mwr) ? 4'b0100 : 4'b0000), {28'd0, mask}, {28'd0, (mrd || mwr) ? 4'b0100 : 4'b0000});
            if (busy) busy_total++;
            if (mrd || mwr) check("strobe_overlap", !(mrd && mwr), {31'd0, mwr}, 32'd0);
            if (mrd) begin
                rd_seen++;
                check("rd_strobe_width", !prev_rd, {31'd0, prev_rd}, 32'd0);
                match_event(K_RD, maddr, 32'd0);
            end
            if (mwr) begin
                wr_seen++;
                check("wr_strobe_width", !prev_wr, {31'd0, prev_wr}, 32'd0);
                match_event(K_WR, maddr, mwdata);
            end
            if (done) match_event(K_DONE, 32'd0, {16'd0, words_done});
            if (err)  match_event(K_ERR, 32'd0, {16'd0, words_done});
        end
        prev_rd = rst ? 1'b0 : mrd;
        prev_wr = rst ? 1'b0 : mwr;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic start_pulse(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        start = 1'b1; src = s; dst = d; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] val);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy == 1'b0, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, done == 1'b0, {31'd0, done}, 32'd0);
        check({tag, "_err"}, err == 1'b0, {31'd0, err}, 32'd0);
        check({tag, "_words_done"}, words_done == 16'd0, {16'd0, words_done}, 32'd0);
        check({tag, "_addr"}, maddr == 32'd0, maddr, 32'd0);
        check({tag, "_wdata"}, mwdata == 32'd0, mwdata, 32'd0);
        check({tag, "_memread"}, mrd == 1'b0, {31'd0, mrd}, 32'd0);
        check({tag, "_memwrite"}, mwr == 1'b0, {31'd0, mwr}, 32'd0);
        check({tag, "_mask"}, mask == 4'd0, {28'd0, mask}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, b0, r0, w0, n;
        rst = 1'b1; start = 1'b0; src = 32'd0; dst = 32'd0; len = 16'd0;
        hang = 1'b0; pre_we = 1'b0; pre_idx = 10'd0; pre_val = 32'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        preload(10'h000, 32'h0000_00A1);
        preload(10'h001, 32'h0000_00B2);
        preload(10'h002, 32'h0000_00C3);
        preload(10'h080, 32'h1111_1111);
        preload(10'h081, 32'h2222_2222);
        preload(10'h082, 32'h3333_3333);
        preload(10'h3FF, 32'hCAFE_F00D);

        // Three-word copy: 8 cycles per word, done right after the last write handshake.
        t0 = cyc; b0 = busy_total;
        push(K_RD, 32'h1000, 32'd0, 0);
        push(K_WR, 32'h1100, 32'h0000_00A1, 0);
        push(K_RD, 32'h1004, 32'd0, 0);
        push(K_WR, 32'h1104, 32'h0000_00B2, 0);
        push(K_RD, 32'h1008, 32'd0, 0);
        push(K_WR, 32'h1108, 32'h0000_00C3, 0);
        push(K_DONE, 32'd0, 32'd3, t0 + 25);
        start_pulse(32'h1000, 32'h1100, 16'd3);
        wait_quiet(200);
        check("copy3_busy_cycles", busy_total - b0 == 24, 32'(busy_total - b0), 32'd24);
        check("copy3_words_done", words_done == 16'd3, {16'd0, words_done}, 32'd3);
        check("copy3_mem0", mem[10'h040] == 32'h0000_00A1, mem[10'h040], 32'h0000_00A1);
        check("copy3_mem1", mem[10'h041] == 32'h0000_00B2, mem[10'h041], 32'h0000_00B2);
        check("copy3_mem2", mem[10'h042] == 32'h0000_00C3, mem[10'h042], 32'h0000_00C3);

        // Zero length: done next cycle, no bus traffic.
        t0 = cyc; b0 = busy_total; r0 = rd_seen; w0 = wr_seen;
        push(K_DONE, 32'd0, 32'd0, t0 + 1);
        start_pulse(32'h2000, 32'h2100, 16'd0);
        wait_quiet(20);
        check("len0_no_reads", rd_seen == r0, 32'(rd_seen - r0), 32'd0);
        check("len0_no_writes", wr_seen == w0, 32'(wr_seen - w0), 32'd0);
        check("len0_no_busy", busy_total == b0, 32'(busy_total - b0), 32'd0);

        // Misaligned source, then misaligned destination.
        t0 = cyc; b0 = busy_total; r0 = rd_seen; w0 = wr_seen;
        push(K_ERR, 32'd0, 32'd0, t0 + 1);
        start_pulse(32'h1002, 32'h1100, 16'd4);
        wait_quiet(20);
        t0 = cyc;
        push(K_ERR, 32'd0, 32'd0, t0 + 1);
        start_pulse(32'h1000, 32'h1101, 16'd1);
        wait_quiet(20);
        check("align_no_reads", rd_seen == r0, 32'(rd_seen - r0), 32'd0);
        check("align_no_writes", wr_seen == w0, 32'(wr_seen - w0), 32'd0);
        check("align_no_busy", busy_total == b0, 32'(busy_total - b0), 32'd0);

        // Stall stuck high after the first read: err 64 cycles after entering RD_WAIT_LO.
        hang = 1'b1;
        t0 = cyc; b0 = busy_total;
        push(K_RD, 32'h1000, 32'd0, 0);
        push(K_ERR, 32'd0, 32'd0, t0 + 67);
        start_pulse(32'h1000, 32'h1100, 16'd2);
        wait_quiet(200);
        check("timeout_busy", busy == 1'b0, {31'd0, busy}, 32'd0);
        check("timeout_words_done", words_done == 16'd0, {16'd0, words_done}, 32'd0);
        check("timeout_busy_cycles", busy_total - b0 == 66, 32'(busy_total - b0), 32'd66);
        rst = 1'b1;
        repeat (2) tick();
        hang = 1'b0;
        rst = 1'b0;
        tick();

        // Reset during WR_WAIT_LO of word 2.
        w0 = wr_seen;
        push(K_RD, 32'h1200, 32'd0, 0);
        push(K_WR, 32'h1300, 32'h1111_1111, 0);
        push(K_RD, 32'h1204, 32'd0, 0);
        push(K_WR, 32'h1304, 32'h2222_2222, 0);
        start_pulse(32'h1200, 32'h1300, 16'd3);
        n = 0;
        while (wr_seen < w0 + 2 && n < 200) begin
            tick();
            n++;
        end
        check("reach_word2_write", wr_seen >= w0 + 2, 32'(wr_seen - w0), 32'd2);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_queue_empty", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        t0 = cyc;
        push(K_RD, 32'h1208, 32'd0, 0);
        push(K_WR, 32'h1308, 32'h3333_3333, 0);
        push(K_DONE, 32'd0, 32'd1, t0 + 9);
        start_pulse(32'h1208, 32'h1308, 16'd1);
        wait_quiet(100);
        check("after_reset_mem", mem[10'h0C2] == 32'h3333_3333, mem[10'h0C2], 32'h3333_3333);

        // Start while busy is ignored.
        t0 = cyc;
        push(K_RD, 32'h1000, 32'd0, 0);
        push(K_WR, 32'h1400, 32'h0000_00A1, 0);
        push(K_RD, 32'h1004, 32'd0, 0);
        push(K_WR, 32'h1404, 32'h0000_00B2, 0);
        push(K_DONE, 32'd0, 32'd2, t0 + 17);
        start_pulse(32'h1000, 32'h1400, 16'd2);
        repeat (5) tick();
        start_pulse(32'h1800, 32'h1900, 16'd5);
        wait_quiet(200);
        check("busy_start_words_done", words_done == 16'd2, {16'd0, words_done}, 32'd2);

        // Source address wraps past 0xFFFFFFFC to 0.
        t0 = cyc;
        push(K_RD, 32'hFFFF_FFFC, 32'd0, 0);
        push(K_WR, 32'h1500, 32'hCAFE_F00D, 0);
        push(K_RD, 32'h0000_0000, 32'd0, 0);
        push(K_WR, 32'h1504, 32'h0000_00A1, 0);
        push(K_DONE, 32'd0, 32'd2, t0 + 17);
        start_pulse(32'hFFFF_FFFC, 32'h1500, 16'd2);
        wait_quiet(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_word_copier.md
Name: dma_word_copier

Overview:
- Bus initiator that drives the data memory's request/stall interface (addr, write_data, memwrite, memread, sign_mask, read_data, clk_stall) from the requesting side.
- Copies a block of 32-bit words from src_addr to dst_addr without CPU involvement.
- Each word is one read transaction followed by one write transaction, with the memory's clk_stall handshake obeyed on both.
- Sits beside the core's load/store path; the top level muxes its mem_* outputs onto the data memory while busy=1.

Parameters:
- LEN_W, 16, width of length and progress counters.
- TIMEOUT, 64, max cycles spent in any wait state before aborting with err.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; sampled only in IDLE
- src_addr  in  32  byte address of first source word
- dst_addr  in  32  byte address of first destination word
- len  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after an accepted start until completion or abort
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on alignment error or timeout
- words_done  out  LEN_W  words fully written so far; holds its value after done/err until the next accepted start
- mem_addr  out  32  request address
- mem_write_data  out  32  store data
- mem_memwrite  out  1  write request strobe
- mem_memread  out  1  read request strobe
- mem_sign_mask  out  4  fixed 4'b0100 (unsigned word) whenever a strobe is high, else 0
- mem_read_data  in  32  load data from memory
- mem_clk_stall  in  1  memory busy flag

Behaviour:
- Reset values: busy=0, done=0, err=0, words_done=0, all mem_* outputs 0, state IDLE.
- Reset mid-transfer aborts immediately with no done/err. The memory may still be finishing an access, so the integrator must reset both together.
- States: IDLE, RD_REQ, RD_WAIT_HI, RD_WAIT_LO, WR_REQ, WR_WAIT_HI, WR_WAIT_LO, FINISH.
- IDLE: start=1 latches src, dst, len and clears words_done.
  - src[1:0]!=0 or dst[1:0]!=0: err pulse next cycle, stay IDLE, no bus traffic.
  - len=0: done pulse next cycle, no bus traffic.
  - Otherwise go to RD_REQ with busy=1.
- RD_REQ: mem_memread=1 and mem_addr=current src for exactly one cycle, then RD_WAIT_HI.
- RD_WAIT_HI: wait for mem_clk_stall=1, then RD_WAIT_LO.
- RD_WAIT_LO: wait for mem_clk_stall=0.
  - In that cycle mem_read_data is valid. Capture it into the data register, then go to WR_REQ.
- WR_REQ: mem_memwrite=1, mem_addr=current dst, mem_write_data=captured word, for exactly one cycle. Then WR_WAIT_HI, followed by WR_WAIT_LO, with the same stall rules as the read side.
- On leaving WR_WAIT_LO:
  - words_done+=1, src+=4, dst+=4. Addresses wrap modulo 2^32 silently.
  - If words_done+1==len go to FINISH, else go to RD_REQ.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- Strobes are never held for two consecutive cycles; the memory would start a second access.
- mem_addr and mem_write_data hold their last value outside request cycles.
- Timeout: a counter clears on entry to each WAIT state.
  - If it reaches TIMEOUT, pulse err, drop busy and go to IDLE.
  - words_done keeps the count of completed words.
- start while busy is ignored.
- With the team's data memory, one word costs exactly 8 cycles: RD_REQ, 2 stall cycles, the capture cycle, then the same four for the write.
- No FIFO; one word is in flight at a time.

Test Plan:
- Copy 3 words, src=0x1000, dst=0x1100, memory preloaded with 0xA1, 0xB2, 0xC3.
  - Required: dst holds the same three words, done pulses once, busy high for 24 cycles, words_done=3.
- len=0, start pulse.
  - Required: done pulses the next cycle, mem_memread and mem_memwrite never assert.
- src=0x1002, len=4.
  - Required: err pulses the next cycle, no strobes, busy stays 0.
- Memory model holds mem_clk_stall=1 forever after the first read.
  - Required: err pulses exactly TIMEOUT (64) cycles after entering RD_WAIT_LO, busy=0, words_done=0.
- reset asserted during WR_WAIT_LO of word 2.
  - Required: all outputs 0 asynchronously, no done/err; a new start afterwards completes normally.
- start pulsed again while busy.
  - Required: ignored; the transfer finishes with the original len.
- Strobe-width check on every scenario: each strobe stays high for exactly 1 cycle.
